// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ctrl_pkg
//  Description : Shared encodings for the multicycle RV32I-subset control
//                path: FSM state codes, opcodes, ALU operations and the
//                datapath mux-select encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  // FSM state encoding (4-bit, legacy-compatible constants)
  localparam logic [3:0] c_st_fetch    = 4'd0;
  localparam logic [3:0] c_st_decode   = 4'd1;
  localparam logic [3:0] c_st_memadr   = 4'd2;
  localparam logic [3:0] c_st_memread  = 4'd3;
  localparam logic [3:0] c_st_memwb    = 4'd4;
  localparam logic [3:0] c_st_memwrite = 4'd5;
  localparam logic [3:0] c_st_execr    = 4'd6;
  localparam logic [3:0] c_st_execi    = 4'd7;
  localparam logic [3:0] c_st_aluwb    = 4'd8;
  localparam logic [3:0] c_st_branch   = 4'd9;
  localparam logic [3:0] c_st_jal      = 4'd10;
  localparam logic [3:0] c_st_jalr1    = 4'd11;
  localparam logic [3:0] c_st_jalr2    = 4'd12;
  localparam logic [3:0] c_st_trap     = 4'd13;

  // Opcodes of the supported subset
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  // ALU operations
  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b101;

  // Result mux
  localparam logic [1:0] c_res_aluout    = 2'b00;
  localparam logic [1:0] c_res_readdata  = 2'b01;
  localparam logic [1:0] c_res_aluresult = 2'b10;

  // ALU operand A mux
  localparam logic [1:0] c_srca_pc    = 2'b00;
  localparam logic [1:0] c_srca_oldpc = 2'b01;
  localparam logic [1:0] c_srca_rs1   = 2'b10;

  // ALU operand B mux
  localparam logic [1:0] c_srcb_rs2  = 2'b00;
  localparam logic [1:0] c_srcb_imm  = 2'b01;
  localparam logic [1:0] c_srcb_four = 2'b10;

  // Immediate format select
  localparam logic [1:0] c_imm_i = 2'b00;
  localparam logic [1:0] c_imm_s = 2'b01;
  localparam logic [1:0] c_imm_b = 2'b10;
  localparam logic [1:0] c_imm_j = 2'b11;

  // Immediate format is a pure function of the opcode; unknown formats use I
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      c_op_store:  return c_imm_s;
      c_op_branch: return c_imm_b;
      c_op_jal:    return c_imm_j;
      default:     return c_imm_i;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mc_alu_decoder
//  Description : Combinational ALU-operation decode from opcode and funct
//                fields. R-type honours funct7[5] (add/sub); I-type ignores
//                it. Anything unrecognised decodes to add.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [2:0] o_alu_control
);

  // Map funct fields to an ALU operation for the R and I arithmetic groups
  always_comb begin
    o_alu_control = c_alu_add;
    if (i_op == c_op_rtype) begin
      case ({i_funct3, i_funct7_5})
        4'b000_0: o_alu_control = c_alu_add;
        4'b000_1: o_alu_control = c_alu_sub;
        4'b010_0: o_alu_control = c_alu_slt;
        4'b110_0: o_alu_control = c_alu_or;
        4'b111_0: o_alu_control = c_alu_and;
        default:  o_alu_control = c_alu_add;
      endcase
    end else if (i_op == c_op_itype) begin
      case (i_funct3)
        3'b000:  o_alu_control = c_alu_add;
        3'b010:  o_alu_control = c_alu_slt;
        3'b110:  o_alu_control = c_alu_or;
        3'b111:  o_alu_control = c_alu_and;
        default: o_alu_control = c_alu_add;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Main control FSM of the multicycle RV32I-subset core.
//                Sequences the shared ALU, memory port and register file,
//                stalls on mem_ready and counts retired instructions.
//                Optional build macro ILLEGAL_TRAP_EN: unknown opcodes park
//                the FSM in TRAP (illegal=1) instead of retiring as a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  logic [3:0]       r_state;
  logic [3:0]       w_next_state;
  logic [CNT_W-1:0] r_instret;
  logic [2:0]       w_dec_alu;

  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic [1:0] w_result_src;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [2:0] w_alu_ctl;
  logic       w_reg_write;
  logic       w_retire;

  mc_alu_decoder u_alu_dec (
    .i_op          (op),
    .i_funct3      (funct3),
    .i_funct7_5    (funct7_5),
    .o_alu_control (w_dec_alu)
  );

  // Next-state selection
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_fetch:    w_next_state = mem_ready ? c_st_decode : c_st_fetch;
      c_st_decode: begin
        case (op)
          c_op_load,
          c_op_store:  w_next_state = c_st_memadr;
          c_op_rtype:  w_next_state = c_st_execr;
          c_op_itype:  w_next_state = c_st_execi;
          c_op_branch: w_next_state = c_st_branch;
          c_op_jal:    w_next_state = c_st_jal;
          c_op_jalr:   w_next_state = c_st_jalr1;
`ifdef ILLEGAL_TRAP_EN
          default:     w_next_state = c_st_trap;
`else
          default:     w_next_state = c_st_fetch;
`endif
        endcase
      end
      c_st_memadr:   w_next_state = (op == c_op_load) ? c_st_memread : c_st_memwrite;
      c_st_memread:  w_next_state = mem_ready ? c_st_memwb : c_st_memread;
      c_st_memwb:    w_next_state = c_st_fetch;
      c_st_memwrite: w_next_state = mem_ready ? c_st_fetch : c_st_memwrite;
      c_st_execr:    w_next_state = c_st_aluwb;
      c_st_execi:    w_next_state = c_st_aluwb;
      c_st_aluwb:    w_next_state = c_st_fetch;
      c_st_branch:   w_next_state = c_st_fetch;
      c_st_jal:      w_next_state = c_st_aluwb;
      c_st_jalr1:    w_next_state = c_st_jalr2;
      c_st_jalr2:    w_next_state = c_st_aluwb;
      c_st_trap:     w_next_state = c_st_trap;
      default:       w_next_state = c_st_fetch;
    endcase
  end

  // Per-state datapath controls (Moore, except the noted mem_ready/Zero/funct terms)
  always_comb begin
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_result_src = c_res_aluout;
    w_src_a      = c_srca_pc;
    w_src_b      = c_srcb_rs2;
    w_alu_ctl    = c_alu_add;
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      c_st_fetch: begin
        w_src_b      = c_srcb_four;
        w_result_src = c_res_aluresult;
        w_ir_write   = mem_ready;
        w_pc_write   = mem_ready;
      end
      c_st_decode: begin
        w_src_a = c_srca_oldpc;
        w_src_b = c_srcb_imm;
        case (op)
          c_op_load, c_op_store, c_op_rtype, c_op_itype,
          c_op_branch, c_op_jal, c_op_jalr: w_retire = 1'b0;
`ifdef ILLEGAL_TRAP_EN
          default: w_retire = 1'b0;
`else
          // Unknown opcode behaves as a NOP and retires here
          default: w_retire = 1'b1;
`endif
        endcase
      end
      c_st_memadr: begin
        w_src_a = c_srca_rs1;
        w_src_b = c_srcb_imm;
      end
      c_st_memread: begin
        w_adr_src = 1'b1;
      end
      c_st_memwb: begin
        w_result_src = c_res_readdata;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      c_st_memwrite: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = mem_ready;
      end
      c_st_execr: begin
        w_src_a   = c_srca_rs1;
        w_src_b   = c_srcb_rs2;
        w_alu_ctl = w_dec_alu;
      end
      c_st_execi: begin
        w_src_a   = c_srca_rs1;
        w_src_b   = c_srcb_imm;
        w_alu_ctl = w_dec_alu;
      end
      c_st_aluwb: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      c_st_branch: begin
        w_src_a    = c_srca_rs1;
        w_src_b    = c_srcb_rs2;
        w_alu_ctl  = c_alu_sub;
        w_pc_write = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
        w_retire   = 1'b1;
      end
      c_st_jal, c_st_jalr2: begin
        w_src_a    = c_srca_oldpc;
        w_src_b    = c_srcb_four;
        w_pc_write = 1'b1;
      end
      c_st_jalr1: begin
        w_src_a = c_srca_rs1;
        w_src_b = c_srcb_imm;
      end
      default: begin
        w_retire = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_fetch;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Enables are forced low combinationally while reset is held
  assign PCWrite    = w_pc_write  & rst_n;
  assign MemWrite   = w_mem_write & rst_n;
  assign IRWrite    = w_ir_write  & rst_n;
  assign RegWrite   = w_reg_write & rst_n;
  assign instr_done = w_retire    & rst_n;
  assign AdrSrc     = w_adr_src;
  assign ResultSrc  = w_result_src;
  assign ALUSrcA    = w_src_a;
  assign ALUSrcB    = w_src_b;
  assign ALUControl = w_alu_ctl;
  assign ImmSrc     = imm_src_of(op);
  assign instret    = r_instret;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = rst_n & (r_state == c_st_trap);
`else
  assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Scoreboard bench for multicycle_controller. Stimulus pushes
//                the hand-derived control vector of every cycle; a monitor
//                pops and compares at each falling edge (and on an
//                asynchronous reset assertion).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = 7'b0110011;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7_5 = 1'b0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_done(instr_done),
    .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] v;
    logic [31:0] cnt;
    string       nm;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 0;
  string       cur = "reset";

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,instr_done,illegal}
  function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] ac, input logic [1:0] imm,
                                     input logic rw, input logic dn, input logic il);
    return {pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, dn, il};
  endfunction

  // Monitor: compare whenever a cycle (or an async reset event) is observed
  initial begin
    exp_t        e;
    logic [17:0] act;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, instr_done, illegal};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s ctrl: got %b want %b", e.nm, act, e.v);
        end
        checks++;
        if (instret !== e.cnt) begin
          errors++;
          $display("FAIL %s instret: got %0d want %0d", e.nm, instret, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic cyc(input logic [17:0] v);
    q.push_back('{v, exp_cnt, cur});
    @(posedge clk); #1;
  endtask

  task automatic cyc_ret(input logic [17:0] v);
    cyc(v);
    exp_cnt = exp_cnt + 1;
  endtask

  task automatic fetch(input int stalls, input logic [1:0] imm);
    for (int i = 0; i < stalls; i++) begin
      mem_ready = 1'b0;
      cyc(mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,imm,0,0,0));
    end
    mem_ready = 1'b1;
    cyc(mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,imm,0,0,0));
  endtask

  task automatic decode(input logic [1:0] imm);
    cyc(mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,imm,0,0,0));
  endtask

  task automatic aluwb(input logic [1:0] imm);
    cyc_ret(mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,imm,1,1,0));
  endtask

  task automatic r_alu(input string n, input logic [2:0] f3, input logic f75,
                       input logic [2:0] ac, input int fstall);
    cur = n; op = 7'b0110011; funct3 = f3; funct7_5 = f75;
    fetch(fstall, 2'b00);
    decode(2'b00);
    cyc(mk(0,0,0,0,2'b00,2'b10,2'b00,ac,2'b00,0,0,0));
    aluwb(2'b00);
  endtask

  task automatic i_alu(input string n, input logic [2:0] f3, input logic f75,
                       input logic [2:0] ac);
    cur = n; op = 7'b0010011; funct3 = f3; funct7_5 = f75;
    fetch(0, 2'b00);
    decode(2'b00);
    cyc(mk(0,0,0,0,2'b00,2'b10,2'b01,ac,2'b00,0,0,0));
    aluwb(2'b00);
  endtask

  task automatic lw(input int stalls);
    cur = "lw"; op = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    fetch(0, 2'b00);
    decode(2'b00);
    cyc(mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0,0));
    for (int i = 0; i < stalls; i++) begin
      mem_ready = 1'b0;
      cyc(mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
    end
    mem_ready = 1'b1;
    cyc(mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
    cyc_ret(mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,1,0));
  endtask

  task automatic sw(input int stalls);
    cur = "sw"; op = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
    fetch(0, 2'b01);
    decode(2'b01);
    cyc(mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0,0));
    for (int i = 0; i < stalls; i++) begin
      mem_ready = 1'b0;
      cyc(mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0,0));
    end
    mem_ready = 1'b1;
    cyc_ret(mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,1,0));
  endtask

  task automatic branch(input string n, input logic [2:0] f3, input logic z,
                        input logic taken);
    cur = n; op = 7'b1100011; funct3 = f3; funct7_5 = 1'b0; Zero = z;
    fetch(0, 2'b10);
    decode(2'b10);
    cyc_ret(mk(taken,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,1,0));
    Zero = 1'b0;
  endtask

  task automatic jal();
    cur = "jal"; op = 7'b1101111; funct3 = 3'b000;
    fetch(0, 2'b11);
    decode(2'b11);
    cyc(mk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0,0));
    aluwb(2'b11);
  endtask

  task automatic jalr();
    cur = "jalr"; op = 7'b1100111; funct3 = 3'b000;
    fetch(0, 2'b00);
    decode(2'b00);
    cyc(mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0,0));
    cyc(mk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b00,0,0,0));
    aluwb(2'b00);
  endtask

  initial begin
    // Reset state: enables low, counter zero, FETCH muxing visible
    @(posedge clk); #1;
    cyc(mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0));
    cyc(mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0));

    // sw aborted by an asynchronous reset in its second MEMWRITE stall cycle
    rst_n = 1'b1;
    cur = "sw_abort"; op = 7'b0100011; funct3 = 3'b010;
    fetch(0, 2'b01);
    decode(2'b01);
    cyc(mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0,0));
    mem_ready = 1'b0;
    cyc(mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0,0));
    q.push_back('{mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0,0), exp_cnt, cur});
    @(negedge clk); #3;
    cur = "async_rst";
    q.push_back('{mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0), exp_cnt, cur});
    rst_n = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    cyc(mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0));
    rst_n = 1'b1;

    // ALU groups
    r_alu("add", 3'b000, 1'b0, 3'b000, 0);
    r_alu("sub", 3'b000, 1'b1, 3'b001, 2);
    r_alu("slt", 3'b010, 1'b0, 3'b101, 0);
    r_alu("or",  3'b110, 1'b0, 3'b011, 0);
    r_alu("and", 3'b111, 1'b0, 3'b010, 0);
    r_alu("r_unk", 3'b001, 1'b0, 3'b000, 0);
    i_alu("addi_f7", 3'b000, 1'b1, 3'b000);
    i_alu("slti", 3'b010, 1'b0, 3'b101);
    i_alu("ori",  3'b110, 1'b0, 3'b011);
    i_alu("andi", 3'b111, 1'b1, 3'b010);

    // Memory with stalls
    lw(2);
    sw(3);
    lw(0);
    sw(0);

    // Branches and jumps
    branch("beq_z1", 3'b000, 1'b1, 1'b1);
    branch("bne_z1", 3'b001, 1'b1, 1'b0);
    branch("bne_z0", 3'b001, 1'b0, 1'b1);
    branch("beq_z0", 3'b000, 1'b0, 1'b0);
    branch("bf3_z1", 3'b100, 1'b1, 1'b0);
    jal();
    jalr();

    // Unknown opcode
    cur = "illegal"; op = 7'b1111111; funct3 = 3'b000;
    fetch(0, 2'b00);
`ifdef ILLEGAL_TRAP_EN
    decode(2'b00);
    for (int i = 0; i < 3; i++)
      cyc(mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,1));
`else
    cyc_ret(mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,1,0));
    r_alu("add_after_nop", 3'b000, 1'b0, 3'b000, 0);
`endif

    // Drain the scoreboard, bounded
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors + ((q.size() != 0) ? 1 : 0));
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multicycle RV32I subset core (add/sub/and/or/slt, addi/andi/ori/slti, lw, sw, beq/bne, jal, jalr).
- Sequences one shared ALU, one shared instruction/data memory port and the register file across multiple cycles per instruction.
- Sits beside the datapath. It reads the latched instruction fields and ALU Zero, and drives all mux selects and write enables.
- Stalls on a memory-ready handshake.
- Keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter instret (wraps modulo 2^CNT_W).

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  reset: one clock; reset is asynchronous and active-low
op  in  7  opcode from instruction register (stable from DECODE onward)
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
Zero  in  1  ALU result == 0
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  load PC from Result
AdrSrc  out  1  memory address: 0 = PC, 1 = Result
MemWrite  out  1  memory write strobe
IRWrite  out  1  load instruction register and OldPC
ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register A
ALUSrcB  out  2  00 rs2 register B, 01 ImmExt, 10 constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; decoded combinationally from op, 00 for others
RegWrite  out  1  register file write
instr_done  out  1  one-cycle pulse on the retiring cycle
instret  out  CNT_W  count of retired instructions
illegal  out  1  illegal-opcode flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n low):
  - State = FETCH, instret = 0, illegal = 0.
  - PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced 0 while rst_n is low.
  - First fetch begins on the first clk edge after release.
- Outputs are Moore (decoded from state). Exceptions:
  - IRWrite, PCWrite and MemWrite are gated by mem_ready where noted.
  - BRANCH PCWrite depends on Zero.
  - ALUControl in EXECR/EXECI depends on funct fields.
- Unlisted outputs in each state are 0 / 00 / add.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite = PCWrite = mem_ready. Stay while !mem_ready; else -> DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut). Next state by op:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR1
    - other -> see Optional Feature
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. -> MEMREAD if op=lw, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, retire -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. On mem_ready: retire -> FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from funct decode -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUControl from funct3 decode (funct7_5 ignored) -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, retire -> FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = (funct3=000 & Zero) | (funct3=001 & !Zero); PCWrite=0 for other funct3. Retire -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (writes OldPC+4 to rd).
  - JALR1: ALUSrcA=10, ALUSrcB=01, add (target into ALUOut) -> JALR2.
  - JALR2: same outputs as JAL -> ALUWB.
- Funct decode:
  - R-type (funct3, funct7_5): {000,0} add; {000,1} sub; {010,0} slt; {110,0} or; {111,0} and; anything else add.
  - I-type (funct3): 000 addi; 010 slti; 110 ori; 111 andi; anything else add.
- Retire means: instr_done=1 for that cycle and instret += 1.
- Latency with mem_ready tied 1 (cycles per instruction): beq/bne 3, R/I-ALU 4, sw 4, jal 4, lw 5, jalr 5.
  - Each cycle mem_ready is low adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Async reset mid-instruction aborts it: no retire, no write enables.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined:
  - Unknown op in DECODE -> TRAP.
  - TRAP: all enables 0, illegal=1, no retire, stays in TRAP until reset.
- Undefined:
  - Unknown op in DECODE is treated as NOP: retire -> FETCH.
  - illegal is tied 0.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALUControl codes
  - ResultSrc / ALUSrcA / ALUSrcB / ImmSrc encodings
- Sub-module mc_alu_decoder: combinational (op, funct3, funct7_5) -> ALUControl.
- FSM and instret counter live in multicycle_controller.

Test Plan:
- add (funct3=000, funct7_5=0), mem_ready=1:
  - states FETCH, DECODE, EXECR, ALUWB.
  - RegWrite=1 only in cycle 4; instr_done pulses once; instret 0 -> 1.
- lw with mem_ready low for 2 cycles in MEMREAD:
  - 7 cycles total; AdrSrc=1 throughout MEMREAD; RegWrite with ResultSrc=01 in the final cycle.
- sw with mem_ready low for 3 MEMWRITE cycles:
  - MemWrite=1 for 4 consecutive cycles, then 0; RegWrite never asserted.
- Branches:
  - beq, Zero=1 -> PCWrite=1 in the BRANCH cycle.
  - bne, Zero=1 -> PCWrite=0.
  - Each takes 3 cycles with ALUControl=001.
- jalr:
  - JALR1 shows ALUSrcA=10, ALUSrcB=01.
  - JALR2 shows PCWrite=1, ALUSrcA=01, ALUSrcB=10.
  - ALUWB shows RegWrite=1.
  - 5 cycles total.
- Reset and illegal opcode:
  - rst_n pulsed low during MEMWRITE -> MemWrite drops immediately (asynchronously); FETCH after release; instret unchanged from 0.
  - op=1111111 with ILLEGAL_TRAP_EN defined -> illegal=1, enables stay 0.
  - op=1111111 with ILLEGAL_TRAP_EN undefined -> retires as NOP in 2 cycles.
